// File: rtl/unidad_logico_aritmetica_secuencial.sv
// Registered parametrised ALU with a valid/busy handshake.
// Single-cycle logic/arithmetic ops; iterative unsigned MUL (shift-add) and
// DIV (restoring) over N cycles. The divider is built only when the macro
// ALU_SECUENCIAL_DIV_EN is defined; otherwise opcode 1111 returns zero.
module unidad_logico_aritmetica_secuencial #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         entrada_valida,
    input  logic [N-1:0] operador1,
    input  logic [N-1:0] operador2,
    input  logic [3:0]   ALUControl,
    output logic         ocupado,
    output logic         salida_valida,
    output logic [N-1:0] resultadoFinal,
    output logic         flagNegativo,
    output logic         flagCero,
    output logic         flagCarry,
    output logic         flagOverflow
);

    localparam int unsigned CW     = $clog2(N);
    localparam logic [3:0]  OP_MUL = 4'b1110;
`ifdef ALU_SECUENCIAL_DIV_EN
    localparam logic [3:0]  OP_DIV = 4'b1111;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_SECUENCIAL_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_MUL  = 2'd1
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cuenta_q, cuenta_d;
    logic [N-1:0]     opnd_q, opnd_d;      // multiplicand (MUL) or divisor (DIV)
    logic [2*N-1:0]   acum_q, acum_d;      // product, or {remainder, quotient}
    logic [N-1:0]     res_q, res_d;
    logic             fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;
    logic             valida_q, valida_d;

    logic [N:0]       suma, resta;
    logic [N-1:0]     alu_res;
    logic             alu_c, alu_v;
    logic [N:0]       mul_suma;
    logic [2*N-1:0]   mul_sig;
`ifdef ALU_SECUENCIAL_DIV_EN
    logic [N:0]       div_desp, div_dif;
    logic [2*N-1:0]   div_sig;
`endif
    logic             escribe;
    logic [N-1:0]     res_nuevo;
    logic             c_nuevo, v_nuevo;

    // Single-cycle operation set evaluated on the live request inputs
    always_comb begin
        suma    = {1'b0, operador1} + {1'b0, operador2};
        resta   = {1'b0, operador1} - {1'b0, operador2};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            4'b0000: alu_res = operador1 & operador2;
            4'b0001: alu_res = operador1 | operador2;
            4'b0010: alu_res = operador1 ^ operador2;
            4'b0011: alu_res = ~operador1;
            4'b0100: alu_res = operador1 >> 1;
            4'b0101: alu_res = operador1 << 1;
            4'b0110: alu_res = operador2 >> 1;
            4'b0111: alu_res = operador2 << 1;
            4'b1000: begin
                alu_res = suma[N-1:0];
                alu_c   = suma[N];
                alu_v   = (operador1[N-1] == operador2[N-1]) && (suma[N-1] != operador1[N-1]);
            end
            4'b1001: begin
                alu_res = resta[N-1:0];
                alu_c   = ~resta[N];
                alu_v   = (operador1[N-1] != operador2[N-1]) && (resta[N-1] != operador1[N-1]);
            end
            4'b1010: alu_res = {operador1[N-1], operador1[N-1:1]};
            4'b1011: alu_res = operador1 << 1;
            4'b1100: alu_res = {operador2[N-1], operador2[N-1:1]};
            4'b1101: alu_res = operador2 << 1;
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_suma = {1'b0, acum_q[2*N-1:N]} + {1'b0, (acum_q[0] ? opnd_q : {N{1'b0}})};
        mul_sig  = {mul_suma, acum_q[N-1:1]};
`ifdef ALU_SECUENCIAL_DIV_EN
        div_desp = {acum_q[2*N-1:N], acum_q[N-1]};
        div_dif  = div_desp - {1'b0, opnd_q};
        if (!div_dif[N]) div_sig = {div_dif[N-1:0], acum_q[N-2:0], 1'b1};
        else             div_sig = {div_desp[N-1:0], acum_q[N-2:0], 1'b0};
`endif
    end

    // Next-state, iteration control and result/flag write-back
    always_comb begin
        estado_d  = estado_q;
        cuenta_d  = cuenta_q;
        opnd_d    = opnd_q;
        acum_d    = acum_q;
        res_d     = res_q;
        fn_d      = fn_q;
        fz_d      = fz_q;
        fc_d      = fc_q;
        fv_d      = fv_q;
        valida_d  = 1'b0;
        escribe   = 1'b0;
        res_nuevo = '0;
        c_nuevo   = 1'b0;
        v_nuevo   = 1'b0;
        case (estado_q)
            S_IDLE: begin
                if (entrada_valida) begin
                    if (ALUControl == OP_MUL) begin
                        estado_d = S_MUL;
                        cuenta_d = CW'(N - 1);
                        opnd_d   = operador1;
                        acum_d   = {{N{1'b0}}, operador2};
                    end
`ifdef ALU_SECUENCIAL_DIV_EN
                    else if ((ALUControl == OP_DIV) && (operador2 != '0)) begin
                        estado_d = S_DIV;
                        cuenta_d = CW'(N - 1);
                        opnd_d   = operador2;
                        acum_d   = {{N{1'b0}}, operador1};
                    end
                    else if (ALUControl == OP_DIV) begin
                        escribe   = 1'b1;
                        res_nuevo = '1;
                        v_nuevo   = 1'b1;
                    end
`endif
                    else begin
                        escribe   = 1'b1;
                        res_nuevo = alu_res;
                        c_nuevo   = alu_c;
                        v_nuevo   = alu_v;
                    end
                end
            end
            S_MUL: begin
                acum_d   = mul_sig;
                cuenta_d = cuenta_q - CW'(1);
                if (cuenta_q == '0) begin
                    estado_d  = S_IDLE;
                    cuenta_d  = '0;
                    escribe   = 1'b1;
                    res_nuevo = mul_sig[N-1:0];
                    c_nuevo   = |mul_sig[2*N-1:N];
                end
            end
`ifdef ALU_SECUENCIAL_DIV_EN
            S_DIV: begin
                acum_d   = div_sig;
                cuenta_d = cuenta_q - CW'(1);
                if (cuenta_q == '0) begin
                    estado_d  = S_IDLE;
                    cuenta_d  = '0;
                    escribe   = 1'b1;
                    res_nuevo = div_sig[N-1:0];
                end
            end
`endif
            default: estado_d = S_IDLE;
        endcase
        if (escribe) begin
            res_d    = res_nuevo;
            fn_d     = res_nuevo[N-1];
            fz_d     = (res_nuevo == '0);
            fc_d     = c_nuevo;
            fv_d     = v_nuevo;
            valida_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= S_IDLE;
            cuenta_q <= '0;
            opnd_q   <= '0;
            acum_q   <= '0;
            res_q    <= '0;
            fn_q     <= 1'b0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            fv_q     <= 1'b0;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cuenta_q <= cuenta_d;
            opnd_q   <= opnd_d;
            acum_q   <= acum_d;
            res_q    <= res_d;
            fn_q     <= fn_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
            fv_q     <= fv_d;
            valida_q <= valida_d;
        end
    end

    assign ocupado        = (estado_q != S_IDLE);
    assign salida_valida  = valida_q;
    assign resultadoFinal = res_q;
    assign flagNegativo   = fn_q;
    assign flagCero       = fz_q;
    assign flagCarry      = fc_q;
    assign flagOverflow   = fv_q;

endmodule

// File: tb/tb_unidad_logico_aritmetica_secuencial.sv
// Self-checking bench for unidad_logico_aritmetica_secuencial (N = 8).
// Expected values come from an arithmetic reference model; the divide
// expectations follow whether ALU_SECUENCIAL_DIV_EN is defined.
module tb_unidad_logico_aritmetica_secuencial;

    localparam int unsigned N = 8;

    logic         clk;
    logic         reset;
    logic         entrada_valida;
    logic [N-1:0] operador1, operador2;
    logic [3:0]   ALUControl;
    logic         ocupado, salida_valida;
    logic [N-1:0] resultadoFinal;
    logic         flagNegativo, flagCero, flagCarry, flagOverflow;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [7:0] r;
        logic       n, z, c, v;
        int         ed;     // extra clock edges after acceptance before the result
    } exp_t;

    unidad_logico_aritmetica_secuencial #(.N(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .entrada_valida (entrada_valida),
        .operador1      (operador1),
        .operador2      (operador2),
        .ALUControl     (ALUControl),
        .ocupado        (ocupado),
        .salida_valida  (salida_valida),
        .resultadoFinal (resultadoFinal),
        .flagNegativo   (flagNegativo),
        .flagCero       (flagCero),
        .flagCarry      (flagCarry),
        .flagOverflow   (flagOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: integer arithmetic on the operand values
    function automatic exp_t modelo(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        t    = 0;
        e.c  = 1'b0;
        e.v  = 1'b0;
        e.ed = 0;
        case (op)
            4'd0:  t = ua & ub;
            4'd1:  t = ua | ub;
            4'd2:  t = ua ^ ub;
            4'd3:  t = 255 - ua;
            4'd4:  t = ua / 2;
            4'd5:  t = ua * 2;
            4'd6:  t = ub / 2;
            4'd7:  t = ub * 2;
            4'd8:  begin
                t   = ua + ub;
                e.c = (t > 255);
                e.v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'd9:  begin
                t   = ua - ub;
                e.c = (ua >= ub);
                e.v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'd10: t = sa >>> 1;
            4'd11: t = ua * 2;
            4'd12: t = sb >>> 1;
            4'd13: t = ub * 2;
            4'd14: begin
                t    = ua * ub;
                e.c  = (t > 255);
                e.ed = 8;
            end
            default: begin
`ifdef ALU_SECUENCIAL_DIV_EN
                if (ub == 0) begin
                    t   = 255;
                    e.v = 1'b1;
                end else begin
                    t    = ua / ub;
                    e.ed = 8;
                end
`else
                t = 0;
`endif
            end
        endcase
        e.r = 8'(t);
        e.n = e.r[7];
        e.z = (e.r == 8'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "/res"}, 32'(resultadoFinal), 32'(e.r));
        chk({tag, "/N"},   32'(flagNegativo),   32'(e.n));
        chk({tag, "/Z"},   32'(flagCero),       32'(e.z));
        chk({tag, "/C"},   32'(flagCarry),      32'(e.c));
        chk({tag, "/V"},   32'(flagOverflow),   32'(e.v));
    endtask

    // Issue one request, wait (bounded) for the result and check it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ed, busy;
        e = modelo(op, a, b);
        @(negedge clk);
        entrada_valida = 1'b1;
        ALUControl     = op;
        operador1      = a;
        operador2      = b;
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        operador1      = 8'($urandom);
        operador2      = 8'($urandom);
        ALUControl     = 4'($urandom);
        ed   = 0;
        busy = 0;
        while (salida_valida !== 1'b1 && ed < 40) begin
            if (ocupado === 1'b1) busy++;
            @(posedge clk);
            #1;
            ed++;
        end
        chk({tag, "/latency"}, 32'(ed), 32'(e.ed));
        chk({tag, "/busy_cycles"}, 32'(busy), 32'(e.ed));
        chk({tag, "/ocupado_at_done"}, 32'(ocupado), 32'(0));
        chk_out(tag, e);
        @(posedge clk);
        #1;
        chk({tag, "/pulse_end"}, 32'(salida_valida), 32'(0));
        chk_out({tag, "/hold"}, e);
    endtask

    initial begin
        exp_t e, ea;
        int   ed, seen;
        logic [3:0] bo[3];
        logic [7:0] ba[3];

        reset          = 1'b1;
        entrada_valida = 1'b0;
        operador1      = '0;
        operador2      = '0;
        ALUControl     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        e.r = 8'h00; e.n = 1'b0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.ed = 0;
        chk_out("reset", e);
        chk("reset/ocupado", 32'(ocupado), 32'(0));
        chk("reset/valida", 32'(salida_valida), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // ADD with signed overflow, SUB to zero
        run_op("add_7f_01", 4'b1000, 8'h7F, 8'h01);
        run_op("sub_05_05", 4'b1001, 8'h05, 8'h05);

        // Back-to-back single-cycle ops: NOT, A>>1, A>>>1
        bo[0] = 4'b0011; ba[0] = 8'hA5;
        bo[1] = 4'b0100; ba[1] = 8'h81;
        bo[2] = 4'b1010; ba[2] = 8'h81;
        @(negedge clk);
        entrada_valida = 1'b1;
        ALUControl     = bo[0];
        operador1      = ba[0];
        operador2      = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            e = modelo(bo[i], ba[i], 8'h3C);
            if (i < 2) begin
                ALUControl = bo[i+1];
                operador1  = ba[i+1];
            end else begin
                entrada_valida = 1'b0;
            end
            chk($sformatf("b2b%0d/valida", i), 32'(salida_valida), 32'(1));
            chk_out($sformatf("b2b%0d", i), e);
        end
        @(posedge clk);
        #1;
        chk("b2b/pulse_end", 32'(salida_valida), 32'(0));

        // MUL with overflow into the high half
        run_op("mul_10_10", 4'b1110, 8'h10, 8'h10);

        // ADD held during a MUL is accepted only after the MUL completes
        e  = modelo(4'b1110, 8'h0D, 8'h0B);
        ea = modelo(4'b1000, 8'h02, 8'h03);
        @(negedge clk);
        entrada_valida = 1'b1;
        ALUControl     = 4'b1110;
        operador1      = 8'h0D;
        operador2      = 8'h0B;
        @(posedge clk);
        #1;
        ALUControl = 4'b1000;
        operador1  = 8'h02;
        operador2  = 8'h03;
        ed = 0;
        while (salida_valida !== 1'b1 && ed < 40) begin
            @(posedge clk);
            #1;
            ed++;
        end
        chk("held/mul_latency", 32'(ed), 32'(8));
        chk_out("held/mul", e);
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        chk("held/add_valida", 32'(salida_valida), 32'(1));
        chk_out("held/add", ea);
        @(posedge clk);
        #1;
        chk("held/pulse_end", 32'(salida_valida), 32'(0));

        // Divide, divide by zero (or the disabled-divider behaviour)
        run_op("div_200_7", 4'b1111, 8'd200, 8'd7);
        run_op("div_33_0", 4'b1111, 8'h33, 8'h00);

        // MUL 0x0F x 0x11 then five idle cycles with stable outputs
        run_op("mul_0f_11", 4'b1110, 8'h0F, 8'h11);
        e = modelo(4'b1110, 8'h0F, 8'h11);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stable/valida", 32'(salida_valida), 32'(0));
            chk_out("stable", e);
        end

        // Asynchronous reset during the third MUL iteration
        @(negedge clk);
        entrada_valida = 1'b1;
        ALUControl     = 4'b1110;
        operador1      = 8'h23;
        operador2      = 8'h45;
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        e.r = 8'h00; e.n = 1'b0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.ed = 0;
        chk_out("abort", e);
        chk("abort/ocupado", 32'(ocupado), 32'(0));
        chk("abort/valida", 32'(salida_valida), 32'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (salida_valida === 1'b1 || ocupado === 1'b1) seen++;
        end
        chk("abort/no_pulse", 32'(seen), 32'(0));
        run_op("add_after_abort", 4'b1000, 8'h02, 8'h03);

        // Randomised operations against the model
        for (int k = 0; k < 60; k++) begin
            run_op($sformatf("rnd%0d", k), 4'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
